ucd_ssd_mux: RTL and testbench
==============================

# ucd_ssd_mux

Parametrised multi-digit up/down counter with hex or BCD counting and a time-multiplexed seven-segment display driver, for the Lab 3 counter top level. It replaces the derived slow clock with clock-enable ticks, so all logic stays on the single board clock. It drives the board's common-anode display and the status LEDs directly.

## Interface
- DIGITS, 4, number of displayed digits and counter digits, legal 1..8
- CNT_DIV, 25_000_000, clock cycles per count tick (4 Hz at 100 MHz), ≥2
- SCAN_DIV, 100_000, clock cycles per display digit slot, ≥2

Ports:
- ucd_ssd_mux_clk  in  1  board clock; one clock only
- ucd_ssd_mux_rst  in  1  reset, asynchronous, active-low
- ucd_ssd_mux_hex_en  in  1  switch: count in hex
- ucd_ssd_mux_bcd_en  in  1  switch: count in BCD
- ucd_ssd_mux_sel  in  1  switch: 1 = up, 0 = down
- ucd_ssd_mux_rst_led, _hex_en_led, _bcd_en_led, _sel_led  out  1 each  status LEDs
- ucd_ssd_mux_cc  out  7  segments, active-low, bit0 = a … bit6 = g
- ucd_ssd_mux_an  out  DIGITS  anodes, active-low, bit0 = rightmost (least significant) digit
- ucd_ssd_mux_tick  out  1  one-cycle count-tick strobe, for test

## Operation
- hex_en, bcd_en and sel pass through a 2-flop synchroniser. The LEDs show the synchronised values. rst_led shows the inverse of the raw ucd_ssd_mux_rst, driven combinationally.
- Count tick: a divider counts 0..CNT_DIV-1. tick is high in the cycle the divider equals CNT_DIV-1, then the divider wraps to 0.
- Mode, evaluated on each tick:
  - bcd_en=1, hex_en=0: BCD
  - hex_en=1, bcd_en=0: HEX
  - both or neither: HOLD (count frozen)
- Mode change: when the mode on a tick differs from the last counting mode (HEX/BCD), the counter loads 0 on that tick instead of counting. HOLD does not update the last counting mode.
- HEX: 4·DIGITS-bit binary counter, ±1 per tick, modulo 16^DIGITS.
- BCD: DIGITS nibbles, each 0..9, with ripple carry/borrow. Up from all-9s wraps to 0; down from 0 wraps to all-9s.
- Scan: a divider with period SCAN_DIV cycles advances a digit index 0→DIGITS-1→0. an has exactly one bit low, at the current index. cc shows the decoded nibble of that digit (0-F patterns; '0' = 7'b1000000, 'F' = 7'b0001110).
- Leading zeros are displayed; there is no blanking.

## Timing
- Reset, asynchronous while ucd_ssd_mux_rst=0:
  - both dividers, counter, digit index and last mode = 0
  - an = all 1s, cc = 7'h7F, tick = 0
  - LEDs (except rst_led) = 0
- First edge after reset release: the scan divider starts at 0. an goes to digit 0 when the first scan period expires, at cycle SCAN_DIV after release.
- Switch latency: 2 cycles from input to the mode used by tick logic and to the LEDs.
- Counter register updates on the clock edge that ends the tick-high cycle. The new value reaches cc no later than the next digit-slot change.
- an and cc are both registered and change on the same edge, so there are no mixed-digit glitches.
- Reset asserted mid-count aborts immediately. No partial carry survives.

## Structure
- Package ucd_ssd_pkg holds:
  - mode enum (HOLD, HEX, BCD)
  - the 16-entry active-low segment constant table
  - blank constant 7'h7F
- Sub-module ucd_tick_gen (parameter DIV): divider plus one-cycle strobe. It is instantiated twice, for the count tick and the scan tick.
- The BCD/hex next-value logic stays in ucd_ssd_mux as a per-digit generate loop.

## Test plan
Run with DIGITS=4, CNT_DIV=4, SCAN_DIV=2.
- Reset: hold rst=0 with no clock edge → an=4'hF, cc=7'h7F, tick=0, rst_led=1, and count 0 after release.
- HEX up: hex_en=1, sel=1, 16 ticks → count 0x0010. Preload FFFF via ticks or force, one more tick → 0000.
- BCD down: bcd_en=1, sel=0 from 0000, one tick → 9999. Tick again → 9998.
- BCD carry: up from 0099 → 0100. Up from 9999 → 0000.
- Mode change / HOLD:
  - HEX count at 0x001A, both enables on for 3 ticks → stays 0x001A.
  - Then bcd_en only, next tick → 0000.
- Scan: an cycles 1110→1101→1011→0111, each for 2 cycles. With count 0x3F0A, cc shows A, 0, F, 3 in that order. A reset pulse mid-scan returns an to 1111 asynchronously.

Source files
------------

// File: rtl/ucd_ssd_pkg.sv
// Shared types and constants for the up/down counter and its seven-segment scan driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: counting-mode enum, active-low segment table (bit0 = a ... bit6 = g),
// and the all-segments-off blank pattern.
package ucd_ssd_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_HEX  = 2'd1,
        MODE_BCD  = 2'd2
    } mode_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Packed so that SEG_TABLE[n] is the pattern for nibble n; listed F down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/ucd_tick_gen.sv
// Free-running clock divider producing a one-cycle enable strobe every DIV cycles.
// Latency: strobe is a combinational decode of the divider state (high while it equals DIV-1).
// Backpressure: none; runs continuously.
//
// Ports:
//   i_clk    board clock
//   i_rst_n  asynchronous active-low reset (divider cleared to 0)
//   o_tick   high for one cycle out of every DIV
module ucd_tick_gen #(
    parameter int DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ucd_ssd_mux.sv
// Multi-digit hex/BCD up/down counter with a time-multiplexed common-anode display driver.
// Latency: switches 2 cycles to mode/LEDs; count updates on the tick edge; cc/an update per digit slot.
// Backpressure: none; all timing derives from internal clock-enable ticks.
//
// Ports:
//   ucd_ssd_mux_clk / ucd_ssd_mux_rst       board clock, async active-low reset
//   ucd_ssd_mux_hex_en/_bcd_en/_sel         raw switches (hex mode, BCD mode, 1 = count up)
//   ucd_ssd_mux_*_led                       status LEDs (synchronised switches, inverted raw reset)
//   ucd_ssd_mux_cc [6:0]                    active-low segments of the digit being scanned
//   ucd_ssd_mux_an [DIGITS-1:0]             active-low anodes, bit0 = least significant digit
//   ucd_ssd_mux_tick                        count-tick strobe
module ucd_ssd_mux
    import ucd_ssd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int CNT_DIV  = 25_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic              ucd_ssd_mux_clk,
    input  logic              ucd_ssd_mux_rst,
    input  logic              ucd_ssd_mux_hex_en,
    input  logic              ucd_ssd_mux_bcd_en,
    input  logic              ucd_ssd_mux_sel,
    output logic              ucd_ssd_mux_rst_led,
    output logic              ucd_ssd_mux_hex_en_led,
    output logic              ucd_ssd_mux_bcd_en_led,
    output logic              ucd_ssd_mux_sel_led,
    output logic [6:0]        ucd_ssd_mux_cc,
    output logic [DIGITS-1:0] ucd_ssd_mux_an,
    output logic              ucd_ssd_mux_tick
);

    localparam int CW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // ---------------------------------------------------------------
    // Switch synchronisers: bit0 = hex_en, bit1 = bcd_en, bit2 = sel
    // ---------------------------------------------------------------
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;

    always_ff @(posedge ucd_ssd_mux_clk or negedge ucd_ssd_mux_rst) begin
        if (!ucd_ssd_mux_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {ucd_ssd_mux_sel, ucd_ssd_mux_bcd_en, ucd_ssd_mux_hex_en};
            r_sync2 <= r_sync1;
        end
    end

    logic w_hex;
    logic w_bcd;
    logic w_up;

    assign w_hex = r_sync2[0];
    assign w_bcd = r_sync2[1];
    assign w_up  = r_sync2[2];

    assign ucd_ssd_mux_hex_en_led = w_hex;
    assign ucd_ssd_mux_bcd_en_led = w_bcd;
    assign ucd_ssd_mux_sel_led    = w_up;
    assign ucd_ssd_mux_rst_led    = ~ucd_ssd_mux_rst;

    mode_t w_mode;

    always_comb begin
        w_mode = MODE_HOLD;
        if (w_hex && !w_bcd) begin
            w_mode = MODE_HEX;
        end else if (w_bcd && !w_hex) begin
            w_mode = MODE_BCD;
        end
    end

    // ---------------------------------------------------------------
    // Tick generators
    // ---------------------------------------------------------------
    logic w_cnt_tick;
    logic w_scan_tick;

    ucd_tick_gen #(.DIV(CNT_DIV)) u_cnt_tick (
        .i_clk   (ucd_ssd_mux_clk),
        .i_rst_n (ucd_ssd_mux_rst),
        .o_tick  (w_cnt_tick)
    );

    ucd_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
        .i_clk   (ucd_ssd_mux_clk),
        .i_rst_n (ucd_ssd_mux_rst),
        .o_tick  (w_scan_tick)
    );

    assign ucd_ssd_mux_tick = w_cnt_tick;

    // ---------------------------------------------------------------
    // Next-value logic
    // ---------------------------------------------------------------
    logic [CW-1:0]     r_count;
    mode_t             r_last_mode;
    logic [CW-1:0]     w_hex_next;
    logic [CW-1:0]     w_bcd_next;
    logic [DIGITS-1:0] w_is9;
    logic [DIGITS-1:0] w_is0;
    logic [DIGITS-1:0] w_cin;

    assign w_hex_next = w_up ? (r_count + CW'(1)) : (r_count - CW'(1));

    // Carry into digit i is decided from the lower digits directly (all 9s going
    // up, all 0s going down) rather than rippled through a chain of nets.
    for (genvar i = 0; i < DIGITS; i++) begin : g_bcd
        logic [3:0] w_dig;

        assign w_dig    = r_count[4*i +: 4];
        assign w_is9[i] = (w_dig == 4'd9);
        assign w_is0[i] = (w_dig == 4'd0);

        if (i == 0) begin : g_lsd
            assign w_cin[i] = 1'b1;
        end else begin : g_upper
            assign w_cin[i] = w_up ? (&w_is9[i-1:0]) : (&w_is0[i-1:0]);
        end

        assign w_bcd_next[4*i +: 4] =
            !w_cin[i] ? w_dig :
            w_up      ? (w_is9[i] ? 4'd0 : w_dig + 4'd1) :
                        (w_is0[i] ? 4'd9 : w_dig - 4'd1);
    end

    // A tick in a counting mode different from the last one restarts from zero;
    // HOLD freezes the value and leaves the remembered mode alone.
    always_ff @(posedge ucd_ssd_mux_clk or negedge ucd_ssd_mux_rst) begin
        if (!ucd_ssd_mux_rst) begin
            r_count     <= '0;
            r_last_mode <= MODE_HOLD;
        end else if (w_cnt_tick && (w_mode != MODE_HOLD)) begin
            if (w_mode != r_last_mode) begin
                r_count     <= '0;
                r_last_mode <= w_mode;
            end else if (w_mode == MODE_HEX) begin
                r_count <= w_hex_next;
            end else begin
                r_count <= w_bcd_next;
            end
        end
    end

    // ---------------------------------------------------------------
    // Display scan: anode and segments register together each slot
    // ---------------------------------------------------------------
    logic [IW-1:0]     r_idx;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_cc;
    logic [3:0]        w_cur_nib;

    assign w_cur_nib = r_count[4*r_idx +: 4];

    always_ff @(posedge ucd_ssd_mux_clk or negedge ucd_ssd_mux_rst) begin
        if (!ucd_ssd_mux_rst) begin
            r_idx <= '0;
            r_an  <= '1;
            r_cc  <= SEG_BLANK;
        end else if (w_scan_tick) begin
            r_an  <= ~(DIGITS'(1) << r_idx);
            r_cc  <= SEG_TABLE[w_cur_nib];
            r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end
    end

    assign ucd_ssd_mux_an = r_an;
    assign ucd_ssd_mux_cc = r_cc;

endmodule

// File: tb/tb_ucd_ssd_mux.sv
// Self-checking bench for ucd_ssd_mux with DIGITS=4, CNT_DIV=4, SCAN_DIV=2.
// Table-driven count vectors plus hand-written reset, scan and LED sequences.
module tb_ucd_ssd_mux;

    localparam int DIGITS   = 4;
    localparam int CNT_DIV  = 4;
    localparam int SCAN_DIV = 2;

    logic              clk;
    logic              rst;
    logic              hex_en;
    logic              bcd_en;
    logic              sel;
    logic              rst_led;
    logic              hex_led;
    logic              bcd_led;
    logic              sel_led;
    logic [6:0]        cc;
    logic [DIGITS-1:0] an;
    logic              tick;

    ucd_ssd_mux #(
        .DIGITS   (DIGITS),
        .CNT_DIV  (CNT_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .ucd_ssd_mux_clk        (clk),
        .ucd_ssd_mux_rst        (rst),
        .ucd_ssd_mux_hex_en     (hex_en),
        .ucd_ssd_mux_bcd_en     (bcd_en),
        .ucd_ssd_mux_sel        (sel),
        .ucd_ssd_mux_rst_led    (rst_led),
        .ucd_ssd_mux_hex_en_led (hex_led),
        .ucd_ssd_mux_bcd_en_led (bcd_led),
        .ucd_ssd_mux_sel_led    (sel_led),
        .ucd_ssd_mux_cc         (cc),
        .ucd_ssd_mux_an         (an),
        .ucd_ssd_mux_tick       (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for n count ticks; returns at the falling edge just after the
    // counter update that ends each tick-high cycle.
    task automatic do_ticks(input int n, output bit ok);
        int w;
        ok = 1'b1;
        for (int t = 0; t < n; t++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (tick !== 1'b1 && w < 2*CNT_DIV + 2);
            if (tick !== 1'b1) begin
                ok = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    typedef struct packed {
        logic        hex;
        logic        bcd;
        logic        up;
        logic [15:0] n;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    // Expected per-sample values after reset release (falling edges 1..10).
    logic [3:0] exp_an   [10];
    logic       exp_tick [10];

    // Expected segments for 0x3F0A, digit 0 first: A, 0, F, 3.
    logic [6:0] exp_seg  [4];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         d;
        logic [3:0] seen;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'd1,     16'h0000}; // first HEX tick loads 0
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'd16,    16'h0010};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'd10,    16'h001A};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'd3,     16'h001A}; // both on: hold
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'd1,     16'h0000}; // switch to BCD: load 0
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'd1,     16'h9999}; // down wrap
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'd1,     16'h9998};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'd1,     16'h9999};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'd1,     16'h0000}; // up wrap
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'd99,    16'h0099};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 16'd1,     16'h0100}; // two-digit carry
        vecs[11] = '{1'b0, 1'b1, 1'b0, 16'd1,     16'h0099}; // two-digit borrow
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'd2,     16'h0099}; // neither on: hold
        vecs[13] = '{1'b1, 1'b0, 1'b0, 16'd1,     16'h0000}; // switch to HEX: load 0
        vecs[14] = '{1'b1, 1'b0, 1'b0, 16'd1,     16'hFFFF};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 16'd1,     16'h0000}; // FFFF + 1 wraps
        vecs[16] = '{1'b1, 1'b0, 1'b1, 16'd16137, 16'h3F09};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 16'd2,     16'h3F09}; // hold
        vecs[18] = '{1'b1, 1'b0, 1'b1, 16'd1,     16'h3F0A}; // hold kept HEX as last mode
        vecs[19] = '{1'b1, 1'b1, 1'b1, 16'd1,     16'h3F0A}; // freeze for the scan check

        exp_an   = '{4'hF, 4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE};
        exp_tick = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_seg  = '{7'h08, 7'h40, 7'h0E, 7'h30};

        // ---- Reset without any clock edge ----
        rst    = 1'b1;
        hex_en = 1'b0;
        bcd_en = 1'b0;
        sel    = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("reset_an",    32'(an), 32'hF);
        check("reset_cc",    32'(cc), 32'h7F);
        check("reset_tick",  32'(tick), 32'h0);
        check("reset_rstled", 32'(rst_led), 32'h1);
        check("reset_leds",  32'({hex_led, bcd_led, sel_led}), 32'h0);
        check("reset_count", 32'(dut.r_count), 32'h0);

        repeat (3) @(negedge clk);
        check("reset_held_an", 32'(an), 32'hF);

        // ---- Release; scan order and tick position from the first edge ----
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("release_an_%0d", k + 1), 32'(an), 32'(exp_an[k]));
            check($sformatf("release_tick_%0d", k + 1), 32'(tick), 32'(exp_tick[k]));
        end
        check("release_rstled", 32'(rst_led), 32'h0);
        check("release_count", 32'(dut.r_count), 32'h0);

        // ---- Switch-to-LED latency: two edges ----
        hex_en = 1'b1;
        sel    = 1'b1;
        @(negedge clk);
        check("led_lat_1", 32'({hex_led, sel_led}), 32'h0);
        @(negedge clk);
        check("led_lat_2", 32'({hex_led, sel_led}), 32'h3);

        // ---- Count vectors ----
        for (int v = 0; v < NV; v++) begin
            hex_en = vecs[v].hex;
            bcd_en = vecs[v].bcd;
            sel    = vecs[v].up;
            do_ticks(int'(vecs[v].n), ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL vec_%0d_timeout: tick missing, required within %0d cycles", v, 2*CNT_DIV + 2);
            end else begin
                check($sformatf("vec_%0d_count", v), 32'(dut.r_count), 32'(vecs[v].exp));
                check($sformatf("vec_%0d_leds", v), 32'({hex_led, bcd_led, sel_led}),
                      32'({vecs[v].hex, vecs[v].bcd, vecs[v].up}));
            end
        end

        // ---- Display of the frozen count 0x3F0A ----
        repeat (8) @(negedge clk);
        seen = 4'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            case (an)
                4'hE:    d = 0;
                4'hD:    d = 1;
                4'hB:    d = 2;
                4'h7:    d = 3;
                default: d = -1;
            endcase
            if (d < 0) begin
                check($sformatf("scan_an_onehot_%0d", k), 32'(an), 32'hE);
            end else begin
                seen[d] = 1'b1;
                check($sformatf("scan_cc_digit%0d", d), 32'(cc), 32'(exp_seg[d]));
            end
        end
        check("scan_all_digits", 32'(seen), 32'hF);

        // ---- Reset pulse mid-scan ----
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("midreset_an",     32'(an), 32'hF);
        check("midreset_cc",     32'(cc), 32'h7F);
        check("midreset_tick",   32'(tick), 32'h0);
        check("midreset_count",  32'(dut.r_count), 32'h0);
        check("midreset_leds",   32'({hex_led, bcd_led, sel_led}), 32'h0);
        check("midreset_rstled", 32'(rst_led), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rerelease_an", 32'(an), 32'hF);
        @(negedge clk);
        check("rerelease_an2", 32'(an), 32'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
